// File: rtl/audio_in_pitch_detect.sv
// Pops left ADC samples and measures tone period by hysteresis rising-edge spacing; outputs update 1 cycle after a pop.
// Pops whenever the input FIFO is non-empty, so the Audio_Controller FIFO is the only backpressure.
module audio_in_pitch_detect #(
  parameter logic signed [31:0] THRESH = 32'sd20000000,
  parameter int MIN_PERIOD   = 16,
  parameter int MAX_PERIOD   = 2047,
  parameter int TOL          = 2,
  parameter int STABLE_COUNT = 4,
  parameter int PW           = 12
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          audio_in_available,
  input  logic [31:0]   left_channel_audio_in,
  output logic          read_audio_in,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          tone_present,
  output logic          stable
);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0] MIN_P = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PERIOD);
  localparam logic [PW-1:0] TOL_P = PW'(TOL);
  localparam logic [SW-1:0] SC_P  = SW'(STABLE_COUNT);

  typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} lvl_t;

  lvl_t          state, state_nxt;
  logic          sample_ev, is_high, is_low, rise;
  logic [PW-1:0] cnt, cnt_inc, delta;
  logic          have_edge, first;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic          arm, accept, timeout;

  assign read_audio_in = audio_in_available & resetn;
  assign sample_ev     = read_audio_in;
  assign is_high       = $signed(left_channel_audio_in) >= THRESH;
  assign is_low        = $signed(left_channel_audio_in) <= -THRESH;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    if (sample_ev) begin
      case (state)
        S_INIT: begin
          if (is_high)     state_nxt = S_HIGH;
          else if (is_low) state_nxt = S_LOW;
        end
        S_LOW: begin
          if (is_high) begin
            state_nxt = S_HIGH;
            rise      = 1'b1;
          end
        end
        S_HIGH: begin
          if (is_low) state_nxt = S_LOW;
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // cnt_inc is the edge-to-edge distance if this sample turns out to be a rising edge
  always_comb begin
    cnt_inc = cnt + 1'b1;
    arm     = rise & ~have_edge;
    accept  = rise & have_edge & (cnt_inc >= MIN_P);
    timeout = sample_ev & ~arm & ~accept & (cnt_inc >= MAX_P);
    delta   = (cnt_inc >= period) ? (cnt_inc - period) : (period - cnt_inc);
    if (first)               stab_nxt = '0;
    else if (delta <= TOL_P) stab_nxt = (stab_cnt == SC_P) ? SC_P : stab_cnt + 1'b1;
    else                     stab_nxt = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      have_edge    <= 1'b0;
      first        <= 1'b0;
      stab_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
      stable       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (sample_ev) begin
        if (arm) begin
          have_edge <= 1'b1;
          cnt       <= '0;
          first     <= 1'b1;
        end else if (accept) begin
          period       <= cnt_inc;
          period_valid <= 1'b1;
          tone_present <= 1'b1;
          cnt          <= '0;
          first        <= 1'b0;
          stab_cnt     <= stab_nxt;
          stable       <= (stab_nxt == SC_P);
        end else begin
          // glitch edges fall through here: counting continues from the last accepted edge
          cnt <= (cnt == MAX_P) ? cnt : cnt_inc;
          if (timeout) begin
            tone_present <= 1'b0;
            stable       <= 1'b0;
            stab_cnt     <= '0;
            have_edge    <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_in_pitch_detect.sv
// Bench for audio_in_pitch_detect: square-wave vector table, hand corner sequences and random
// segments, every pop compared against a sample-index based reference model.
module tb_audio_in_pitch_detect;
  localparam int TH  = 20000000;
  localparam int MIN = 16;
  localparam int MAX = 2047;
  localparam int TOL = 2;
  localparam int SC  = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_channel_audio_in = '0;
  logic        read_audio_in;
  logic [11:0] period;
  logic        period_valid, tone_present, stable;

  audio_in_pitch_detect dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in), .read_audio_in(read_audio_in),
    .period(period), .period_valid(period_valid), .tone_present(tone_present), .stable(stable)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // reference model: sample index of the last accepted edge and the list of periods since arming
  int m_lvl, m_idx, m_last;
  bit m_armed;
  int q[$];
  int e_period;
  bit e_pv, e_tone, e_stable;

  typedef struct {
    bit rst; int amp; int lo; int hi; int n; int gap;
    int exp_pulses; int exp_period; bit exp_tone; bit exp_stable;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_idx = 0; m_last = 0; m_armed = 0; q.delete();
    e_period = 0; e_pv = 0; e_tone = 0; e_stable = 0;
  endtask

  task automatic model_step(input logic [31:0] raw);
    int s, d, dd;
    bit rise;
    s = $signed(raw);
    rise = 0;
    e_pv = 0;
    if (s >= TH) begin
      rise = (m_lvl == -1);
      m_lvl = 1;
    end else if (s <= -TH) begin
      m_lvl = -1;
    end
    d = m_idx - m_last;
    if (rise && !m_armed) begin
      m_armed = 1; m_last = m_idx; q.delete();
    end else if (rise && d >= MIN) begin
      e_period = d; e_pv = 1; e_tone = 1; m_last = m_idx; q.push_back(d);
    end else if (m_armed && d >= MAX) begin
      m_armed = 0; e_tone = 0; q.delete();
    end
    e_stable = 0;
    if (q.size() >= SC + 1) begin
      e_stable = 1;
      for (int i = q.size() - SC; i < q.size(); i++) begin
        dd = q[i] - q[i-1];
        if (dd < 0) dd = -dd;
        if (dd > TOL) e_stable = 0;
      end
    end
    m_idx++;
  endtask

  // called and returns at posedge+1
  task automatic pop(input logic [31:0] s, input int gap);
    audio_in_available = 1'b1;
    left_channel_audio_in = s;
    #1 check("read_audio_in", read_audio_in, 1);
    @(posedge CLOCK_50); #1;
    audio_in_available = 1'b0;
    model_step(s);
    check("period", period, e_period);
    check("flags{valid,tone,stable}", {period_valid, tone_present, stable}, {e_pv, e_tone, e_stable});
    if (period_valid) pulses++;
    for (int g = 0; g < gap; g++) begin
      @(posedge CLOCK_50); #1;
      if (g == 0) check("idle_period_valid", period_valid, 0);
    end
  endtask

  task automatic run_square(input int amp, input int lo, input int hi, input int n, input int gap);
    logic [31:0] s;
    for (int k = 0; k < n; k++) begin
      s = ((k % (lo + hi)) < lo) ? -amp : amp;
      pop(s, gap);
    end
  endtask

  task automatic do_reset();
    audio_in_available = 1'b1;
    left_channel_audio_in = 32'd100000000;
    resetn = 1'b0;
    #1;
    check("rst_read", read_audio_in, 0);
    check("rst_period", period, 0);
    check("rst_flags", {period_valid, tone_present, stable}, 0);
    @(posedge CLOCK_50); #1;
    check("rst_hold_flags", {period_valid, tone_present, stable}, 0);
    audio_in_available = 1'b0;
    resetn = 1'b1;
    model_reset();
    pulses = 0;
  endtask

  initial begin
    logic [31:0] s;
    int lo, hi, n, gap, amp, sel;

    tbl[0] = '{1, 100000000,  8, 8,   96,    0, 5, 16, 1, 1};
    tbl[1] = '{0, 100000000,  9, 8,   51,    0, 3, 17, 1, 1};
    tbl[2] = '{0, 100000000, 12, 8,  100,    0, 5, 20, 1, 1};
    tbl[3] = '{1,  10000000,  8, 8,  500,    0, 0,  0, 0, 0};
    tbl[4] = '{1, 100000000,  8, 8,   96,    0, 5, 16, 1, 1};
    tbl[5] = '{0, 100000000,  0, 1, 2100,    0, 0, 16, 0, 0};
    tbl[6] = '{0, 100000000,  8, 8,   48,    0, 2, 16, 1, 0};
    tbl[7] = '{1, 100000000,  8, 8,   26, 1041, 1, 16, 1, 0};

    // held in reset with data waiting: no pops, all outputs low
    audio_in_available = 1'b1;
    left_channel_audio_in = 32'd100000000;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("init_read", read_audio_in, 0);
    check("init_period", period, 0);
    check("init_flags", {period_valid, tone_present, stable}, 0);
    resetn = 1'b1;
    #1 check("release_read", read_audio_in, 1);
    audio_in_available = 1'b0;
    model_reset();
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      pulses = 0;
      run_square(tbl[i].amp, tbl[i].lo, tbl[i].hi, tbl[i].n, tbl[i].gap);
      check($sformatf("row%0d_pulses", i), pulses, tbl[i].exp_pulses);
      check($sformatf("row%0d_period", i), period, tbl[i].exp_period);
      check($sformatf("row%0d_tone", i), tone_present, tbl[i].exp_tone);
      check($sformatf("row%0d_stable", i), stable, tbl[i].exp_stable);
    end

    // reset mid-tone clears at once, then re-locks after two edges
    run_square(100000000, 8, 8, 20, 0);
    check("pre_reset_tone", tone_present, 1);
    do_reset();
    run_square(100000000, 8, 8, 26, 0);
    check("relock_pulses", pulses, 1);
    check("relock_period", period, 16);
    check("relock_tone", tone_present, 1);

    // short glitch edge between arm and next edge does not restart the count
    do_reset();
    pop(-100000000, 0);
    pop(100000000, 0);
    repeat (4) pop(-100000000, 0);
    pop(100000000, 0);
    check("glitch_no_valid", period_valid, 0);
    repeat (10) pop(-100000000, 0);
    pop(100000000, 0);
    check("glitch_period", period, 16);
    check("glitch_valid", period_valid, 1);

    // exact threshold levels: +/-THRESH switch, +/-(THRESH-1) do not
    do_reset();
    pop(-TH, 0);
    pop(TH, 0);
    repeat (5) pop(-(TH - 1), 0);
    repeat (10) pop(-TH, 0);
    pop(TH - 1, 0);
    check("thresh_minus1_no_edge", period_valid, 0);
    pop(TH, 0);
    check("thresh_period", period, 17);

    // edge landing exactly on MAX_PERIOD is accepted
    do_reset();
    pop(-100000000, 0);
    pop(100000000, 0);
    repeat (MAX - 1) pop(-100000000, 0);
    pop(100000000, 0);
    check("max_period", period, MAX);
    check("max_valid", period_valid, 1);

    // one sample later: timeout first, the edge only re-arms
    do_reset();
    pop(-100000000, 0);
    pop(100000000, 0);
    repeat (MAX) pop(-100000000, 0);
    pop(100000000, 0);
    check("over_max_valid", period_valid, 0);
    check("over_max_period", period, 0);
    check("over_max_tone", tone_present, 0);

    // random square segments with noise, gaps and varied amplitudes
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      lo  = $urandom_range(2, 20);
      hi  = $urandom_range(2, 20);
      n   = $urandom_range(20, 120);
      gap = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      amp = (sel == 0) ? 10000000 : (sel == 1) ? TH : (sel == 2) ? 100000000 : 2000000000;
      for (int k = 0; k < n; k++) begin
        s = ((k % (lo + hi)) < lo) ? -amp : amp;
        if ($urandom_range(0, 9) == 0) s = $urandom();
        pop(s, gap);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
